// File: rtl/sram_waddr_gen.sv
// sram_waddr_gen: turns decoded pixel writes into linear frame-buffer SRAM
// writes. Pixels are addressed by walking the current CASET/RASET window,
// queued in a small show-ahead FIFO, and drained whenever the SRAM accepts.
// A clear request replaces the pixel path with a full-frame zero fill.
module sram_waddr_gen #(
   parameter int DISP_W     = 160,
   parameter int DISP_H     = 128,
   parameter int ADDR_W     = 15,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [31:0]       i_col_addr,
   input  logic [31:0]       i_row_addr,
   input  logic              i_waddr_set_req,
   input  logic              i_write_req,
   input  logic [15:0]       i_pixel_data,
   input  logic              i_clr_req,
   input  logic              i_sram_ready,
   output logic              o_sram_we,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [15:0]       o_sram_wdata,
   output logic              o_busy,
   output logic              o_overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int CW    = 16;

   localparam logic [CW-1:0]     X_MAX      = CW'(DISP_W - 1);
   localparam logic [CW-1:0]     Y_MAX      = CW'(DISP_H - 1);
   localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(DISP_W);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DISP_W * DISP_H - 1);
   localparam logic [CNT_W-1:0]  FIFO_FULL  = CNT_W'(FIFO_DEPTH);

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [15:0]       data;
   } entry_t;

   function automatic logic [CW-1:0] clamp(input logic [CW-1:0] v, input logic [CW-1:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   state_e            state_q, state_d;
   logic [CW-1:0]     xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
   logic [CW-1:0]     x_q, x_d, y_q, y_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ovf_q, ovf_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   entry_t            fifo_mem [FIFO_DEPTH];

   logic              in_idle, start_clear, accept_px;
   logic              fifo_empty, fifo_full, push, pop, drop;
   logic [ADDR_W-1:0] push_addr;
   logic [CW-1:0]     set_xs, set_xe, set_ys, set_ye;
   entry_t            head;

   // FIFO handshake decode: pushes only in IDLE, a pop frees a slot in the same cycle.
   always_comb begin
      // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
      in_idle     = (state_q == ST_IDLE);
      fifo_empty  = (count_q == '0);
      fifo_full   = (count_q == FIFO_FULL);
      start_clear = in_idle & i_clr_req;
      accept_px   = in_idle & ~i_clr_req & i_write_req;
      pop         = in_idle & ~fifo_empty & i_sram_ready;
      push        = accept_px & (~fifo_full | pop);
      drop        = accept_px & fifo_full & ~pop;
      push_addr   = ADDR_W'(y_q) * ROW_STRIDE + ADDR_W'(x_q);
   end

   // FIFO pointers, occupancy and sticky overflow; a clear flushes everything.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q | drop;
      if (start_clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Window bounds and cursor: clear resets, a window set beats a cursor advance.
   always_comb begin
      set_xs = clamp(i_col_addr[31:16], X_MAX);
      set_xe = clamp(i_col_addr[15:0], X_MAX);
      set_ys = clamp(i_row_addr[31:16], Y_MAX);
      set_ye = clamp(i_row_addr[15:0], Y_MAX);
      if (set_xe < set_xs) set_xe = set_xs;
      if (set_ye < set_ys) set_ye = set_ys;

      xs_d = xs_q;
      xe_d = xe_q;
      ys_d = ys_q;
      ye_d = ye_q;
      x_d  = x_q;
      y_d  = y_q;
      if (start_clear) begin
         xs_d = '0;
         xe_d = X_MAX;
         ys_d = '0;
         ye_d = Y_MAX;
         x_d  = '0;
         y_d  = '0;
      end else if (i_waddr_set_req) begin
         xs_d = set_xs;
         xe_d = set_xe;
         ys_d = set_ys;
         ye_d = set_ye;
         x_d  = set_xs;
         y_d  = set_ys;
      end else if (accept_px) begin
         if (x_q == xe_q) begin
            x_d = xs_q;
            y_d = (y_q == ye_q) ? ys_q : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   // IDLE/CLEAR next state; the fill counter only moves when the SRAM accepts.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (i_clr_req) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = '0;
            end
         end
         ST_CLEAR: begin
            if (i_clr_req) begin
               clr_cnt_d = '0;
            end else if (i_sram_ready) begin
               if (clr_cnt_q == LAST_ADDR) begin
                  state_d   = ST_IDLE;
                  clr_cnt_d = '0;
               end else begin
                  clr_cnt_d = clr_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // SRAM port: zero fill while clearing, otherwise the FIFO head (held until accepted).
   always_comb begin
      head         = fifo_mem[rd_ptr_q];
      o_busy       = (state_q == ST_CLEAR);
      o_overflow   = ovf_q;
      o_sram_we    = 1'b0;
      o_sram_addr  = '0;
      o_sram_wdata = '0;
      if (state_q == ST_CLEAR) begin
         o_sram_we   = 1'b1;
         o_sram_addr = clr_cnt_q;
      end else if (!fifo_empty) begin
         o_sram_we    = 1'b1;
         o_sram_addr  = head.addr;
         o_sram_wdata = head.data;
      end
   end

   // FIFO storage write.
   always_ff @(posedge i_clk) begin
      // NOTE: the storage array is deliberately not reset; empty pointers make stale entries unreachable.
      if (push) fifo_mem[wr_ptr_q] <= '{addr: push_addr, data: i_pixel_data};
   end

   // State registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (i_rst) begin
         state_q   <= ST_IDLE;
         xs_q      <= '0;
         xe_q      <= X_MAX;
         ys_q      <= '0;
         ye_q      <= Y_MAX;
         x_q       <= '0;
         y_q       <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         xs_q      <= xs_d;
         xe_q      <= xe_d;
         ys_q      <= ys_d;
         ye_q      <= ye_d;
         x_q       <= x_d;
         y_q       <= y_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

endmodule

// File: tb/tb_sram_waddr_gen.sv
// Scoreboard bench for sram_waddr_gen: stimulus pushes expected SRAM writes,
// a negedge monitor pops and compares every accepted write.
module tb_sram_waddr_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] col_addr, row_addr;
   logic        waddr_set_req, write_req, clr_req, sram_ready;
   logic [15:0] pixel_data;
   logic        sram_we, busy, overflow;
   logic [14:0] sram_addr;
   logic [15:0] sram_wdata;

   always #5 clk = ~clk;

   sram_waddr_gen dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_col_addr      (col_addr),
      .i_row_addr      (row_addr),
      .i_waddr_set_req (waddr_set_req),
      .i_write_req     (write_req),
      .i_pixel_data    (pixel_data),
      .i_clr_req       (clr_req),
      .i_sram_ready    (sram_ready),
      .o_sram_we       (sram_we),
      .o_sram_addr     (sram_addr),
      .o_sram_wdata    (sram_wdata),
      .o_busy          (busy),
      .o_overflow      (overflow)
   );

   typedef struct packed {
      logic [14:0] addr;
      logic [15:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   peek_en  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: a write is accepted at the next posedge when we & ready at negedge.
   always @(negedge clk) begin
      if (!rst && sram_we && sram_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", sram_addr, sram_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 32'(sram_addr), 32'(mon_e.addr));
            check("wr_data", 32'(sram_wdata), 32'(mon_e.data));
         end
      end else if (!rst && sram_we && peek_en && exp_q.size() > 0) begin
         check("hold_addr", 32'(sram_addr), 32'(exp_q[0].addr));
         check("hold_data", 32'(sram_wdata), 32'(exp_q[0].data));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] d, input logic [14:0] a, input bit expect_it, input bit with_set);
      write_req     = 1'b1;
      pixel_data    = d;
      waddr_set_req = with_set;
      if (expect_it) exp_q.push_back('{addr: a, data: d});
      tick();
      write_req     = 1'b0;
      waddr_set_req = 1'b0;
   endtask

   task automatic set_win(input logic [31:0] c, input logic [31:0] r);
      col_addr      = c;
      row_addr      = r;
      waddr_set_req = 1'b1;
      tick();
      waddr_set_req = 1'b0;
   endtask

   task automatic drain(input int max_cycles);
      int n = 0;
      while (exp_q.size() > 0 && n < max_cycles) begin
         tick();
         n++;
      end
      check("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int n;
      rst = 1'b1; col_addr = '0; row_addr = '0; waddr_set_req = 1'b0;
      write_req = 1'b0; clr_req = 1'b0; sram_ready = 1'b1; pixel_data = '0;
      tick(); tick();
      rst = 1'b0;
      check("rst_we", 32'(sram_we), 32'd0);
      check("rst_addr", 32'(sram_addr), 32'd0);
      check("rst_wdata", 32'(sram_wdata), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);

      // Full-screen walk from reset, plus first-write latency.
      check("lat_before", 32'(sram_we), 32'd0);
      wr(16'hAAAA, 15'd0, 1'b1, 1'b0);
      check("lat_after", 32'(sram_we), 32'd1);
      wr(16'hBBBB, 15'd1, 1'b1, 1'b0);
      wr(16'hCCCC, 15'd2, 1'b1, 1'b0);
      drain(20);

      // Small window with wrap: x 2..3, y 5..6.
      set_win(32'h0002_0003, 32'h0005_0006);
      wr(16'h0001, 15'd802, 1'b1, 1'b0);
      wr(16'h0002, 15'd803, 1'b1, 1'b0);
      wr(16'h0003, 15'd962, 1'b1, 1'b0);
      wr(16'h0004, 15'd963, 1'b1, 1'b0);
      wr(16'h0005, 15'd802, 1'b1, 1'b0);
      drain(20);

      // Stall: 6 pushes into a 4-deep FIFO, last two dropped but cursor advances.
      sram_ready = 1'b0;
      peek_en    = 1'b1;
      wr(16'h0011, 15'd803, 1'b1, 1'b0);
      wr(16'h0012, 15'd962, 1'b1, 1'b0);
      wr(16'h0013, 15'd963, 1'b1, 1'b0);
      wr(16'h0014, 15'd802, 1'b1, 1'b0);
      wr(16'h0015, 15'd0, 1'b0, 1'b0);
      wr(16'h0016, 15'd0, 1'b0, 1'b0);
      check("ovf_set", 32'(overflow), 32'd1);
      tick(); tick(); tick();
      peek_en    = 1'b0;
      sram_ready = 1'b1;
      drain(20);
      check("ovf_sticky", 32'(overflow), 32'd1);

      // Clamp: XE=255 -> 159, single row 0; then XS>XE collapses to XE=XS.
      set_win(32'h009E_00FF, 32'h0000_0000);
      wr(16'h0021, 15'd158, 1'b1, 1'b0);
      wr(16'h0022, 15'd159, 1'b1, 1'b0);
      wr(16'h0023, 15'd158, 1'b1, 1'b0);
      drain(20);
      set_win(32'h0010_0005, 32'h0001_0001);
      wr(16'h0031, 15'd176, 1'b1, 1'b0);
      wr(16'h0032, 15'd176, 1'b1, 1'b0);
      drain(20);

      // Same-cycle write and set: old cursor for this pixel, new (4,2) afterwards.
      col_addr = 32'h0004_0004;
      row_addr = 32'h0002_0002;
      wr(16'h0041, 15'd176, 1'b1, 1'b1);
      wr(16'h0042, 15'd324, 1'b1, 1'b0);
      wr(16'h0043, 15'd324, 1'b1, 1'b0);
      drain(20);

      // Clear with two pixels pending: they vanish, 20480 zero writes follow.
      sram_ready = 1'b0;
      wr(16'h0051, 15'd0, 1'b0, 1'b0);
      wr(16'h0052, 15'd0, 1'b0, 1'b0);
      for (int i = 0; i < 20480; i++) exp_q.push_back('{addr: 15'(i), data: 16'h0000});
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      check("clr_busy", 32'(busy), 32'd1);
      check("clr_ovf", 32'(overflow), 32'd0);
      check("clr_we", 32'(sram_we), 32'd1);
      check("clr_addr0", 32'(sram_addr), 32'd0);
      peek_en = 1'b1;
      tick(); tick();
      wr(16'h0061, 15'd0, 1'b0, 1'b0);
      sram_ready = 1'b1;
      wr(16'h0062, 15'd0, 1'b0, 1'b0);
      check("clr_ignore_ovf", 32'(overflow), 32'd0);
      n = 0;
      while (exp_q.size() > 0 && n < 25000) begin
         check("busy_in_clear", 32'(busy), 32'd1);
         tick();
         n++;
      end
      peek_en = 1'b0;
      check("clear_left", 32'(exp_q.size()), 32'd0);
      check("busy_after_clear", 32'(busy), 32'd0);

      // After clear: full-screen window, cursor at (0,0).
      wr(16'hABCD, 15'd0, 1'b1, 1'b0);
      wr(16'hABCE, 15'd1, 1'b1, 1'b0);
      drain(20);
      tick();
      check("idle_we", 32'(sram_we), 32'd0);

      // Reset mid-operation with a full FIFO and overflow set.
      sram_ready = 1'b0;
      for (int i = 0; i < 5; i++) wr(16'(16'h0070 + i), 15'd0, 1'b0, 1'b0);
      check("pre_rst_ovf", 32'(overflow), 32'd1);
      rst = 1'b1;
      tick();
      check("mid_rst_we", 32'(sram_we), 32'd0);
      check("mid_rst_addr", 32'(sram_addr), 32'd0);
      check("mid_rst_ovf", 32'(overflow), 32'd0);
      rst = 1'b0;
      sram_ready = 1'b1;
      wr(16'h5555, 15'd0, 1'b1, 1'b0);
      drain(20);

      tick(); tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
